// File: rtl/hub75_pkg.sv
// hub75_pkg: shared definitions for the HUB75 BCM frame scheduler.
//   - FSM state encoding
//   - colour-field offsets into the framebuffer word {R1,G1,B1,R2,G2,B2}
//   - plane display length and a clog2 helper that never returns 0
package hub75_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE     = 3'd0;
  localparam state_t S_FETCH    = 3'd1;
  localparam state_t S_SHIFT_LO = 3'd2;
  localparam state_t S_SHIFT_HI = 3'd3;
  localparam state_t S_BLANK    = 3'd4;
  localparam state_t S_LATCH    = 3'd5;
  localparam state_t S_DISPLAY  = 3'd6;

  // Field index (in units of COLOR_BITS) of each channel; R1 is the MSB field.
  localparam int OFF_R1 = 5;
  localparam int OFF_G1 = 4;
  localparam int OFF_B1 = 3;
  localparam int OFF_R2 = 2;
  localparam int OFF_G2 = 1;
  localparam int OFF_B2 = 0;

  // Display cycles for a bit-plane: weight doubles with significance.
  function automatic int plane_ticks(input int base, input int plane);
    return base << plane;
  endfunction

  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/bcm_display_timer.sv
// bcm_display_timer: down-counter that produces the OE window for one plane.
//   clk_in, rst   : clock, async active-high reset
//   i_load        : load length for i_plane (counter runs from next cycle)
//   i_plane       : bit-plane being displayed
//   o_active      : window open (one cycle per display tick)
//   o_expire      : last cycle of the window
module bcm_display_timer
  import hub75_pkg::*;
#(
  parameter int BASE_TICKS = 4,
  parameter int COLOR_BITS = 4,
  parameter int PLANE_W    = 2
) (
  input  logic               clk_in,
  input  logic               rst,
  input  logic               i_load,
  input  logic [PLANE_W-1:0] i_plane,
  output logic               o_active,
  output logic               o_expire
);

  // Counter holds (length - 1) at most, sized for the heaviest plane.
  localparam int CNT_W = $clog2(plane_ticks(BASE_TICKS, COLOR_BITS - 1) + 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_run;
  logic [CNT_W-1:0] w_load_val;

  assign w_load_val = CNT_W'(plane_ticks(BASE_TICKS, int'(i_plane)) - 1);

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_run <= 1'b0;
    end else if (i_load) begin
      r_cnt <= w_load_val;
      r_run <= 1'b1;
    end else if (r_run) begin
      if (r_cnt == '0) r_run <= 1'b0;
      else             r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_active = r_run;
  assign o_expire = r_run && (r_cnt == '0);

endmodule

// File: rtl/hub75_bcm_scheduler.sv
// hub75_bcm_scheduler: scans rows and BCM bit-planes of a HUB75 panel.
//   clk_in, rst        : clock, async active-high reset
//   enable             : run; sampled only at plane boundaries
//   fb_addr/fb_rd      : framebuffer read {row,column}; data 1 cycle later
//   fb_rdata           : {R1,G1,B1,R2,G2,B2}, COLOR_BITS each
//   R1..B2_data        : serial colour bits to panel
//   A..E               : displayed row address
//   clk_out, LAT, OE_N : panel shift clock, latch, output enable (low)
//   done               : pulse on the last display cycle of a frame
//   busy               : not idle
// Per column: FETCH, SHIFT_LO (capture), SHIFT_HI (clk_out high).
// Per plane: columns, BLANK, LATCH, DISPLAY for BASE_TICKS<<plane cycles.
module hub75_bcm_scheduler
  import hub75_pkg::*;
#(
  parameter int  SCREEN_WIDTH = 32,
  parameter int  SCREEN_DEPTH = 16,
  parameter int  COLOR_BITS   = 4,
  parameter int  BASE_TICKS   = 4,
  localparam int ADDR_W       = $clog2(SCREEN_WIDTH * SCREEN_DEPTH / 2)
) (
  input  logic                    clk_in,
  input  logic                    rst,
  input  logic                    enable,
  output logic [ADDR_W-1:0]       fb_addr,
  output logic                    fb_rd,
  input  logic [6*COLOR_BITS-1:0] fb_rdata,
  output logic                    R1_data,
  output logic                    G1_data,
  output logic                    B1_data,
  output logic                    R2_data,
  output logic                    G2_data,
  output logic                    B2_data,
  output logic                    A,
  output logic                    B,
  output logic                    C,
  output logic                    D,
  output logic                    E,
  output logic                    clk_out,
  output logic                    LAT,
  output logic                    OE_N,
  output logic                    done,
  output logic                    busy
);

  localparam int COL_W   = clog2_min1(SCREEN_WIDTH);
  localparam int ROW_W   = clog2_min1(SCREEN_DEPTH / 2);
  localparam int PLANE_W = clog2_min1(COLOR_BITS);

  localparam logic [COL_W-1:0]   COL_LAST   = COL_W'(SCREEN_WIDTH - 1);
  localparam logic [ROW_W-1:0]   ROW_LAST   = ROW_W'(SCREEN_DEPTH / 2 - 1);
  localparam logic [PLANE_W-1:0] PLANE_LAST = PLANE_W'(COLOR_BITS - 1);

  state_t              r_state, w_next;
  logic [COL_W-1:0]    r_col;
  logic [ROW_W-1:0]    r_row;
  logic [PLANE_W-1:0]  r_plane;
  logic [5:0]          r_rgb;       // [5]=R1 .. [0]=B2
  logic [4:0]          r_row_addr;

  logic                  w_load, w_active, w_expire;
  logic                  w_col_last, w_row_last, w_plane_last;
  logic [5:0]            w_bits;
  logic [COLOR_BITS-1:0] w_field;

  assign w_col_last   = (r_col == COL_LAST);
  assign w_row_last   = (r_row == ROW_LAST);
  assign w_plane_last = (r_plane == PLANE_LAST);

  // Select bit [plane] out of each colour field.
  always_comb begin
    w_bits  = '0;
    w_field = '0;
    for (int k = 0; k < 6; k++) begin
      w_field   = fb_rdata[k*COLOR_BITS +: COLOR_BITS];
      w_bits[k] = w_field[r_plane];
    end
  end

  bcm_display_timer #(
    .BASE_TICKS (BASE_TICKS),
    .COLOR_BITS (COLOR_BITS),
    .PLANE_W    (PLANE_W)
  ) u_timer (
    .clk_in   (clk_in),
    .rst      (rst),
    .i_load   (w_load),
    .i_plane  (r_plane),
    .o_active (w_active),
    .o_expire (w_expire)
  );

  // State register
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next state
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (enable) w_next = S_FETCH;
      S_FETCH:    w_next = S_SHIFT_LO;
      S_SHIFT_LO: w_next = S_SHIFT_HI;
      S_SHIFT_HI: w_next = w_col_last ? S_BLANK : S_FETCH;
      S_BLANK:    w_next = S_LATCH;
      S_LATCH:    w_next = S_DISPLAY;
      S_DISPLAY:  if (w_expire) w_next = enable ? S_FETCH : S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  // Outputs decoded from the state register, so rst forces OE_N high at once.
  always_comb begin
    fb_rd   = (r_state == S_FETCH);
    clk_out = (r_state == S_SHIFT_HI);
    LAT     = (r_state == S_LATCH);
    w_load  = (r_state == S_LATCH);
    OE_N    = !((r_state == S_DISPLAY) && w_active);
    busy    = (r_state != S_IDLE);
    done    = (r_state == S_DISPLAY) && w_expire && w_row_last && w_plane_last;
  end

  // Scan position, shift data and row address.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_col      <= '0;
      r_row      <= '0;
      r_plane    <= '0;
      r_rgb      <= '0;
      r_row_addr <= '0;
    end else begin
      case (r_state)
        S_SHIFT_LO: r_rgb <= {w_bits[OFF_R1], w_bits[OFF_G1], w_bits[OFF_B1],
                              w_bits[OFF_R2], w_bits[OFF_G2], w_bits[OFF_B2]};
        S_SHIFT_HI: begin
          if (w_col_last) begin
            r_col <= '0;
            r_rgb <= '0;  // blank data lines ahead of the latch
          end else begin
            r_col <= r_col + 1'b1;
          end
        end
        // Row address moves on entry to LATCH, well inside the OE_N=1 gap.
        S_BLANK:    r_row_addr <= 5'(r_row);
        S_DISPLAY: begin
          if (w_expire) begin
            if (w_plane_last) begin
              r_plane <= '0;
              r_row   <= w_row_last ? '0 : r_row + 1'b1;
            end else begin
              r_plane <= r_plane + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign fb_addr = ADDR_W'({r_row, r_col});
  assign {R1_data, G1_data, B1_data, R2_data, G2_data, B2_data} = r_rgb;
  assign {E, D, C, B, A} = r_row_addr;

endmodule

// File: tb/tb_hub75_bcm_scheduler.sv
module tb_hub75_bcm_scheduler;
  localparam int TW  = 4;
  localparam int TD  = 4;
  localparam int TC  = 2;
  localparam int TBT = 2;
  localparam int AW  = $clog2(TW * TD / 2);
  localparam int DW  = 6 * TC;
  localparam int NROWS = TD / 2;

  logic clk_in = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0;
  logic [AW-1:0] fb_addr;
  logic fb_rd;
  logic [DW-1:0] fb_rdata = '0;
  logic R1_data, G1_data, B1_data, R2_data, G2_data, B2_data;
  logic A, B, C, D, E;
  logic clk_out, LAT, OE_N, done, busy;

  int n_chk = 0;
  int n_err = 0;
  logic [DW-1:0] mem [TW*NROWS];

  hub75_bcm_scheduler #(
    .SCREEN_WIDTH (TW),
    .SCREEN_DEPTH (TD),
    .COLOR_BITS   (TC),
    .BASE_TICKS   (TBT)
  ) dut (
    .clk_in   (clk_in),
    .rst      (rst),
    .enable   (enable),
    .fb_addr  (fb_addr),
    .fb_rd    (fb_rd),
    .fb_rdata (fb_rdata),
    .R1_data  (R1_data),
    .G1_data  (G1_data),
    .B1_data  (B1_data),
    .R2_data  (R2_data),
    .G2_data  (G2_data),
    .B2_data  (B2_data),
    .A        (A),
    .B        (B),
    .C        (C),
    .D        (D),
    .E        (E),
    .clk_out  (clk_out),
    .LAT      (LAT),
    .OE_N     (OE_N),
    .done     (done),
    .busy     (busy)
  );

  always #5 clk_in = ~clk_in;

  // Framebuffer RAM: one-cycle read latency.
  always @(posedge clk_in) fb_rdata <= fb_rd ? mem[fb_addr] : '0;

  wire [4:0] ra  = {E, D, C, B, A};
  wire [5:0] rgb = {R1_data, G1_data, B1_data, R2_data, G2_data, B2_data};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk_in);
    #1;
  endtask

  function automatic int ticks(input int p);
    return TBT << p;
  endfunction

  // Expected serial bits: bit p of each field, R1 in the MSB field.
  function automatic logic [5:0] exp_rgb(input int addr, input int p);
    logic [DW-1:0] s;
    s = mem[addr] >> p;
    return {s[5*TC], s[4*TC], s[3*TC], s[2*TC], s[TC], s[0]};
  endfunction

  // Reference model: current (row, plane) plus event counts within the plane.
  int m_row = 0, m_plane = 0, n_rd = 0, n_rise = 0, n_low = 0;
  int plane_cyc = 0, lat_cnt = 0;
  logic in_plane = 1'b0, prev_clk = 1'b0, prev_oe = 1'b1, last;
  logic [1:0] rd_hist = '0;
  logic [4:0] prev_ra = '0;

  always @(negedge clk_in) begin
    if (rst) begin
      m_row = 0; m_plane = 0; n_rd = 0; n_rise = 0; n_low = 0;
      plane_cyc = 0; lat_cnt = 0; in_plane = 1'b0;
      prev_clk = 1'b0; prev_oe = 1'b1; rd_hist = '0; prev_ra = '0;
    end else begin
      chk("lat_with_oe", LAT & ~OE_N, 1'b0);
      if (!busy) chk("idle_oe_n", OE_N, 1'b1);
      if (in_plane) plane_cyc++;
      if (fb_rd) begin
        if (!in_plane) begin
          in_plane  = 1'b1;
          plane_cyc = 1;
        end
        chk("fb_addr", fb_addr, m_row * TW + n_rd);
        n_rd++;
      end
      if (clk_out) begin
        chk("clk_after_rd", rd_hist[1], 1'b1);
        if (!prev_clk) begin
          chk("rgb", rgb, exp_rgb(m_row * TW + n_rise, m_plane));
          n_rise++;
        end
      end
      if (LAT) begin
        chk("shifts_per_lat", n_rise, TW);
        chk("row_addr", ra, m_row);
        chk("rgb_blank", rgb, 0);
        lat_cnt++;
      end
      if (!OE_N) begin
        n_low++;
        if (!prev_oe) chk("row_addr_stable", ra, prev_ra);
      end else if (!prev_oe) begin
        chk("oe_low_len", n_low, 0);
      end
      last = !OE_N && (n_low == ticks(m_plane));
      chk("done", done, last && (m_plane == TC - 1) && (m_row == NROWS - 1));
      if (last) begin
        chk("plane_cycles", plane_cyc, 3 * TW + 2 + ticks(m_plane));
        if (m_plane == TC - 1 && m_row == NROWS - 1) begin
          chk("lat_per_frame", lat_cnt, TC * NROWS);
          lat_cnt = 0;
        end
        m_plane++;
        if (m_plane == TC) begin
          m_plane = 0;
          m_row   = (m_row + 1) % NROWS;
        end
        n_rd = 0; n_rise = 0; n_low = 0; in_plane = 1'b0;
      end
      rd_hist  = {rd_hist[0], fb_rd};
      prev_clk = clk_out;
      prev_oe  = OE_N;
      prev_ra  = ra;
    end
  end

  initial begin
    int n, first, second, nd;
    bit ok;
    for (int i = 0; i < TW * NROWS; i++) mem[i] = DW'(12'h03C);

    // Reset state
    repeat (2) tick();
    chk("rst_busy", busy, 1'b0);
    chk("rst_oe_n", OE_N, 1'b1);
    chk("rst_lat", LAT, 1'b0);
    chk("rst_clk_out", clk_out, 1'b0);
    chk("rst_fb_rd", fb_rd, 1'b0);
    chk("rst_fb_addr", fb_addr, 0);
    chk("rst_done", done, 1'b0);
    chk("rst_row_addr", ra, 0);
    chk("rst_rgb", rgb, 0);
    rst = 1'b0;
    tick();

    // Frame timing: done on cycle 68 and 136 counting the first FETCH as 1.
    enable = 1'b1;
    n = 0; first = 0; second = 0;
    while (second == 0 && n < 400) begin
      tick();
      n++;
      if (done) begin
        if (first == 0) first = n;
        else            second = n;
      end
    end
    chk("first_done_cycle", first, 68);
    chk("second_done_cycle", second, 136);
    enable = 1'b0;
    repeat (3) tick();
    chk("stop_busy", busy, 1'b0);
    chk("stop_oe_n", OE_N, 1'b1);

    for (int i = 0; i < TW * NROWS; i++) mem[i] = DW'($urandom);

    // Pause during row 1 plane 0 shifting, then resume.
    enable = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      tick();
      if (m_row == 1 && m_plane == 0 && n_rd > 0) ok = 1'b1;
    end
    chk("pause_point_reached", ok, 1'b1);
    enable = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      tick();
      if (!busy) ok = 1'b1;
    end
    chk("pause_goes_idle", ok, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("pause_busy", busy, 1'b0);
      chk("pause_oe_n", OE_N, 1'b1);
      chk("pause_no_rd", fb_rd, 1'b0);
    end
    enable = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      tick();
      if (fb_rd) ok = 1'b1;
    end
    chk("resume_rd", ok, 1'b1);
    chk("resume_addr", fb_addr, 1 * TW);

    // Ten frames of random data under the protocol monitor.
    nd = 0;
    for (int i = 0; i < 10 * 68 + 200 && nd < 10; i++) begin
      tick();
      if (done) nd++;
    end
    chk("ten_frames", nd, 10);

    // Reset in the middle of DISPLAY.
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      tick();
      if (!OE_N) ok = 1'b1;
    end
    chk("reach_display", ok, 1'b1);
    rst = 1'b1;
    #1;
    chk("async_oe_n", OE_N, 1'b1);
    chk("async_lat", LAT, 1'b0);
    chk("async_busy", busy, 1'b0);
    chk("async_fb_addr", fb_addr, 0);
    chk("async_row_addr", ra, 0);
    chk("async_clk_out", clk_out, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      tick();
      if (fb_rd) ok = 1'b1;
    end
    chk("restart_rd", ok, 1'b1);
    chk("restart_addr", fb_addr, 0);
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      tick();
      if (done) ok = 1'b1;
    end
    chk("restart_frame_done", ok, 1'b1);
    enable = 1'b0;
    repeat (30) tick();
    chk("final_idle", busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
